encode_rx_drv: RTL and testbench

//  Receive-side partner of the PMT encode/scan sync-word link. Oversamples SPI_MCLK/SPI_MOSI in the clk_i

---
 rtl/encode_rx_drv.sv | 196 +++++++++++++++++++
 tb/tb_encode_rx_drv.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/encode_rx_drv.sv
// Receive side of the PMT encode/scan sync-word link: oversamples SPI_MCLK/SPI_MOSI,
// deserializes words MSB first and decodes the sync words into scan state and event pulses.
module encode_rx_drv #(
  parameter int DATA_WIDTH   = 16,
  parameter int SERIAL_MODE  = 1,
  parameter int IDLE_TIMEOUT = 64,
  parameter int CNT_WIDTH    = 32
) (
  input  logic                   clk_i,
  input  logic                   rst_n_i,
  input  logic                   SPI_MCLK,
  input  logic [SERIAL_MODE-1:0] SPI_MOSI,
  output logic                   scan_active_o,
  output logic                   scan_test_o,
  output logic                   scan_begin_pulse_o,
  output logic                   scan_end_pulse_o,
  output logic                   encode_zero_pulse_o,
  output logic [CNT_WIDTH-1:0]   encode_zero_cnt_o,
  output logic                   frame_err_o
);

  localparam int BEATS  = DATA_WIDTH / SERIAL_MODE;
  localparam int BEAT_W = $clog2(BEATS + 1);
  localparam int IDLE_W = $clog2(IDLE_TIMEOUT + 1);

  localparam logic [BEAT_W-1:0]    BEAT_END  = BEAT_W'(BEATS - 1);
  localparam logic [BEAT_W-1:0]    BEAT_ZERO = {BEAT_W{1'b0}};
  localparam logic [BEAT_W-1:0]    BEAT_ONE  = {{(BEAT_W-1){1'b0}}, 1'b1};
  localparam logic [IDLE_W-1:0]    IDLE_LAST = IDLE_W'(IDLE_TIMEOUT);
  localparam logic [IDLE_W-1:0]    IDLE_ZERO = {IDLE_W{1'b0}};
  localparam logic [IDLE_W-1:0]    IDLE_ONE  = {{(IDLE_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_WIDTH-1:0] CNT_ZERO  = {CNT_WIDTH{1'b0}};
  localparam logic [CNT_WIDTH-1:0] CNT_ONE   = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

  localparam logic [DATA_WIDTH-1:0] W_ENCODE = 16'hECDE;
  localparam logic [DATA_WIDTH-1:0] W_BEGIN  = 16'h5A51;
  localparam logic [DATA_WIDTH-1:0] W_TEST   = 16'h5A53;
  localparam logic [DATA_WIDTH-1:0] W_END    = 16'h5A50;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SCAN = 2'd1,
    ST_TEST = 2'd2
  } state_t;

  logic [2:0]                       mclk_sync_r;
  logic [SERIAL_MODE-1:0]           mosi_meta_r;
  logic [SERIAL_MODE-1:0]           mosi_sync_r;
  logic [DATA_WIDTH-SERIAL_MODE-1:0] shift_r;
  logic [DATA_WIDTH-1:0]            shift_in_s;
  logic [DATA_WIDTH-1:0]            word_r;
  logic                             word_valid_r;
  logic [BEAT_W-1:0]                beat_r;
  logic [IDLE_W-1:0]                idle_r;
  logic                             mclk_rise_s;
  logic                             timeout_s;

  state_t                           state_r;
  state_t                           state_next_s;
  logic                             begin_s;
  logic                             end_s;
  logic                             enc_s;
  logic                             dec_err_s;
  logic [CNT_WIDTH-1:0]             cnt_r;
  logic [CNT_WIDTH-1:0]             cnt_next_s;
  logic                             scan_active_r;
  logic                             scan_test_r;
  logic                             begin_r;
  logic                             end_r;
  logic                             enc_r;
  logic                             frame_err_r;

  // mclk_sync_r[2] is the previous synced sample; MOSI stage 2 lines up with MCLK stage 2
  assign mclk_rise_s = mclk_sync_r[1] & ~mclk_sync_r[2];
  assign shift_in_s  = {shift_r, mosi_sync_r};
  assign timeout_s   = (idle_r == IDLE_LAST) && (beat_r != BEAT_ZERO) && !mclk_rise_s;

  // Two-flop synchronizers for the link clock and data lanes
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      mclk_sync_r <= 3'b000;
      mosi_meta_r <= {SERIAL_MODE{1'b0}};
      mosi_sync_r <= {SERIAL_MODE{1'b0}};
    end else begin
      mclk_sync_r <= {mclk_sync_r[1:0], SPI_MCLK};
      mosi_meta_r <= SPI_MOSI;
      mosi_sync_r <= mosi_meta_r;
    end
  end

  // Deserializer with beat counting and idle-timeout abort of partial words
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      shift_r      <= {(DATA_WIDTH-SERIAL_MODE){1'b0}};
      word_r       <= {DATA_WIDTH{1'b0}};
      word_valid_r <= 1'b0;
      beat_r       <= BEAT_ZERO;
      idle_r       <= IDLE_ZERO;
    end else begin
      word_valid_r <= 1'b0;
      if (mclk_rise_s) begin
        idle_r  <= IDLE_ZERO;
        shift_r <= shift_in_s[DATA_WIDTH-SERIAL_MODE-1:0];
        if (beat_r == BEAT_END) begin
          beat_r       <= BEAT_ZERO;
          word_r       <= shift_in_s;
          word_valid_r <= 1'b1;
        end else begin
          beat_r <= beat_r + BEAT_ONE;
        end
      end else begin
        if (idle_r != IDLE_LAST) begin
          idle_r <= idle_r + IDLE_ONE;
        end
        if (timeout_s) begin
          beat_r <= BEAT_ZERO;
        end
      end
    end
  end

  // Sync-word decode: next state, event strobes and revolution counter
  always_comb begin
    state_next_s = state_r;
    begin_s      = 1'b0;
    end_s        = 1'b0;
    enc_s        = 1'b0;
    dec_err_s    = 1'b0;
    cnt_next_s   = cnt_r;
    if (word_valid_r) begin
      case (word_r)
        W_BEGIN: begin
          state_next_s = ST_SCAN;
          begin_s      = 1'b1;
          cnt_next_s   = CNT_ZERO;
        end
        W_TEST: begin
          state_next_s = ST_TEST;
          begin_s      = 1'b1;
          cnt_next_s   = CNT_ZERO;
        end
        W_END: begin
          if (state_r != ST_IDLE) begin
            state_next_s = ST_IDLE;
            end_s        = 1'b1;
          end else begin
            state_next_s = ST_IDLE;
          end
        end
        W_ENCODE: begin
          if (state_r != ST_IDLE) begin
            enc_s      = 1'b1;
            cnt_next_s = cnt_r + CNT_ONE;
          end else begin
            dec_err_s = 1'b1;
          end
        end
        default: dec_err_s = 1'b1;
      endcase
    end else begin
      state_next_s = state_r;
    end
  end

  // State register and registered outputs; status bits follow the next state so they move with the pulses
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_r       <= ST_IDLE;
      cnt_r         <= CNT_ZERO;
      scan_active_r <= 1'b0;
      scan_test_r   <= 1'b0;
      begin_r       <= 1'b0;
      end_r         <= 1'b0;
      enc_r         <= 1'b0;
      frame_err_r   <= 1'b0;
    end else begin
      state_r       <= state_next_s;
      cnt_r         <= cnt_next_s;
      scan_active_r <= (state_next_s != ST_IDLE);
      scan_test_r   <= (state_next_s == ST_TEST);
      begin_r       <= begin_s;
      end_r         <= end_s;
      enc_r         <= enc_s;
      frame_err_r   <= dec_err_s | timeout_s;
    end
  end

  assign scan_active_o       = scan_active_r;
  assign scan_test_o         = scan_test_r;
  assign scan_begin_pulse_o  = begin_r;
  assign scan_end_pulse_o    = end_r;
  assign encode_zero_pulse_o = enc_r;
  assign encode_zero_cnt_o   = cnt_r;
  assign frame_err_o         = frame_err_r;

endmodule

// File: tb/tb_encode_rx_drv.sv
// Directed bench for encode_rx_drv: a 1-lane instance (A) and a 4-lane, 4-bit-counter instance (B).
module tb_encode_rx_drv;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        mclk_a, mclk_b;
  logic [0:0]  mosi_a;
  logic [3:0]  mosi_b;
  logic        act_a, tst_a, beg_a, end_a, enc_a, err_a;
  logic        act_b, tst_b, beg_b, end_b, enc_b, err_b;
  logic [31:0] cnt_a;
  logic [3:0]  cnt_b;

  int errors = 0;
  int checks = 0;
  int n_beg_a = 0, n_end_a = 0, n_enc_a = 0, n_err_a = 0;
  int n_beg_b = 0, n_end_b = 0, n_enc_b = 0, n_err_b = 0;

  always #5 clk = ~clk;

  encode_rx_drv u_dut_a (
    .clk_i(clk), .rst_n_i(rst_n), .SPI_MCLK(mclk_a), .SPI_MOSI(mosi_a),
    .scan_active_o(act_a), .scan_test_o(tst_a), .scan_begin_pulse_o(beg_a),
    .scan_end_pulse_o(end_a), .encode_zero_pulse_o(enc_a),
    .encode_zero_cnt_o(cnt_a), .frame_err_o(err_a)
  );

  encode_rx_drv #(.SERIAL_MODE(4), .CNT_WIDTH(4)) u_dut_b (
    .clk_i(clk), .rst_n_i(rst_n), .SPI_MCLK(mclk_b), .SPI_MOSI(mosi_b),
    .scan_active_o(act_b), .scan_test_o(tst_b), .scan_begin_pulse_o(beg_b),
    .scan_end_pulse_o(end_b), .encode_zero_pulse_o(enc_b),
    .encode_zero_cnt_o(cnt_b), .frame_err_o(err_b)
  );

  // Pulse tallies, sampled on the inactive edge
  always @(negedge clk) begin
    if (beg_a) n_beg_a <= n_beg_a + 1;
    if (end_a) n_end_a <= n_end_a + 1;
    if (enc_a) n_enc_a <= n_enc_a + 1;
    if (err_a) n_err_a <= n_err_a + 1;
    if (beg_b) n_beg_b <= n_beg_b + 1;
    if (end_b) n_end_b <= n_end_b + 1;
    if (enc_b) n_enc_b <= n_enc_b + 1;
    if (err_b) n_err_b <= n_err_b + 1;
  end

  task automatic beat_a(input logic b);
    @(negedge clk); mclk_a = 1'b0; mosi_a = b;
    repeat (4) @(negedge clk);
    @(negedge clk); mclk_a = 1'b1;
    repeat (4) @(negedge clk);
  endtask

  task automatic send_a(input logic [15:0] w, input int nb);
    for (int i = 15; i > 15 - nb; i--) beat_a(w[i]);
    repeat (4) @(negedge clk);
  endtask

  task automatic beat_b(input logic [3:0] n);
    @(negedge clk); mclk_b = 1'b0; mosi_b = n;
    repeat (4) @(negedge clk);
    @(negedge clk); mclk_b = 1'b1;
    repeat (4) @(negedge clk);
  endtask

  task automatic send_b(input logic [15:0] w);
    for (int i = 3; i >= 0; i--) beat_b(w[i*4 +: 4]);
    repeat (4) @(negedge clk);
  endtask

  task automatic test_reset();
    checks++; if ({act_a, tst_a, beg_a, end_a, enc_a, err_a} !== 6'b0) begin errors++; $display("FAIL reset_flags_a: got %b want 000000", {act_a, tst_a, beg_a, end_a, enc_a, err_a}); end
    checks++; if (cnt_a !== 32'd0) begin errors++; $display("FAIL reset_cnt_a: got %0d want 0", cnt_a); end
    checks++; if ({act_b, tst_b, beg_b, end_b, enc_b, err_b, cnt_b} !== 10'b0) begin errors++; $display("FAIL reset_b: got %b want 0", {act_b, tst_b, beg_b, end_b, enc_b, err_b, cnt_b}); end
  endtask

  task automatic test_begin();
    logic [15:0] w = 16'h5A51;
    int lat = 0;
    int b0 = n_beg_a, e0 = n_err_a;
    for (int i = 15; i >= 1; i--) beat_a(w[i]);
    @(negedge clk); mclk_a = 1'b0; mosi_a = w[0];
    repeat (4) @(negedge clk);
    @(negedge clk); mclk_a = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      @(posedge clk); #1;
      if (beg_a && lat == 0) lat = k;
    end
    repeat (4) @(negedge clk);
    checks++; if (lat !== 4) begin errors++; $display("FAIL begin_latency: got %0d want 4", lat); end
    checks++; if (n_beg_a - b0 !== 1) begin errors++; $display("FAIL begin_pulse: got %0d want 1", n_beg_a - b0); end
    checks++; if ({act_a, tst_a} !== 2'b10) begin errors++; $display("FAIL begin_state: got %b want 10", {act_a, tst_a}); end
    checks++; if (cnt_a !== 32'd0) begin errors++; $display("FAIL begin_cnt: got %0d want 0", cnt_a); end
    checks++; if (n_err_a - e0 !== 0) begin errors++; $display("FAIL begin_err: got %0d want 0", n_err_a - e0); end
  endtask

  task automatic test_scan_test();
    int b0 = n_beg_a, n0 = n_enc_a, d0 = n_end_a;
    send_a(16'h5A53, 16);
    checks++; if ({act_a, tst_a} !== 2'b11) begin errors++; $display("FAIL test_state: got %b want 11", {act_a, tst_a}); end
    checks++; if (n_beg_a - b0 !== 1) begin errors++; $display("FAIL test_begin_pulse: got %0d want 1", n_beg_a - b0); end
    repeat (3) send_a(16'hECDE, 16);
    checks++; if (n_enc_a - n0 !== 3) begin errors++; $display("FAIL test_enc_pulses: got %0d want 3", n_enc_a - n0); end
    checks++; if (cnt_a !== 32'd3) begin errors++; $display("FAIL test_cnt: got %0d want 3", cnt_a); end
    send_a(16'h5A50, 16);
    checks++; if (n_end_a - d0 !== 1) begin errors++; $display("FAIL test_end_pulse: got %0d want 1", n_end_a - d0); end
    checks++; if ({act_a, tst_a} !== 2'b00) begin errors++; $display("FAIL test_end_state: got %b want 00", {act_a, tst_a}); end
    checks++; if (cnt_a !== 32'd3) begin errors++; $display("FAIL test_cnt_hold: got %0d want 3", cnt_a); end
  endtask

  task automatic test_errors();
    int e0 = n_err_a, n0 = n_enc_a;
    send_a(16'hECDE, 16);
    checks++; if (n_err_a - e0 !== 1) begin errors++; $display("FAIL err_encode_idle: got %0d want 1", n_err_a - e0); end
    checks++; if (n_enc_a - n0 !== 0) begin errors++; $display("FAIL err_no_enc_pulse: got %0d want 0", n_enc_a - n0); end
    send_a(16'h1234, 16);
    checks++; if (n_err_a - e0 !== 2) begin errors++; $display("FAIL err_unknown: got %0d want 2", n_err_a - e0); end
    checks++; if ({act_a, tst_a} !== 2'b00) begin errors++; $display("FAIL err_state: got %b want 00", {act_a, tst_a}); end
    checks++; if (cnt_a !== 32'd3) begin errors++; $display("FAIL err_cnt: got %0d want 3", cnt_a); end
  endtask

  task automatic test_timeout();
    int e0 = n_err_a, b0 = n_beg_a;
    send_a(16'h5A51, 9);
    repeat (80) @(negedge clk);
    checks++; if (n_err_a - e0 !== 1) begin errors++; $display("FAIL timeout_err: got %0d want 1", n_err_a - e0); end
    send_a(16'h5A51, 16);
    checks++; if (n_beg_a - b0 !== 1) begin errors++; $display("FAIL timeout_then_begin: got %0d want 1", n_beg_a - b0); end
    checks++; if (act_a !== 1'b1) begin errors++; $display("FAIL timeout_active: got %b want 1", act_a); end
    checks++; if (cnt_a !== 32'd0) begin errors++; $display("FAIL timeout_cnt: got %0d want 0", cnt_a); end
    checks++; if (n_err_a - e0 !== 1) begin errors++; $display("FAIL timeout_single_err: got %0d want 1", n_err_a - e0); end
  endtask

  task automatic test_wrap();
    int b0 = n_beg_b, n0 = n_enc_b, e0 = n_err_b;
    send_b(16'h5A51);
    checks++; if ({act_b, tst_b} !== 2'b10) begin errors++; $display("FAIL wrap_begin_state: got %b want 10", {act_b, tst_b}); end
    repeat (15) send_b(16'hECDE);
    checks++; if (cnt_b !== 4'hF) begin errors++; $display("FAIL wrap_cnt_max: got %0d want 15", cnt_b); end
    send_b(16'hECDE);
    checks++; if (cnt_b !== 4'h0) begin errors++; $display("FAIL wrap_cnt_zero: got %0d want 0", cnt_b); end
    checks++; if (n_enc_b - n0 !== 16) begin errors++; $display("FAIL wrap_enc_pulses: got %0d want 16", n_enc_b - n0); end
    send_b(16'hECDE);
    checks++; if (cnt_b !== 4'h1) begin errors++; $display("FAIL wrap_cnt_one: got %0d want 1", cnt_b); end
    send_b(16'h5A51);
    checks++; if (cnt_b !== 4'h0) begin errors++; $display("FAIL rearm_cnt: got %0d want 0", cnt_b); end
    checks++; if (n_beg_b - b0 !== 2) begin errors++; $display("FAIL rearm_begin_pulses: got %0d want 2", n_beg_b - b0); end
    checks++; if ({act_b, tst_b} !== 2'b10) begin errors++; $display("FAIL rearm_state: got %b want 10", {act_b, tst_b}); end
    checks++; if (n_err_b - e0 !== 0) begin errors++; $display("FAIL wrap_err: got %0d want 0", n_err_b - e0); end
  endtask

  task automatic test_reset_mid_word();
    int d0, e0;
    send_a(16'hECDE, 16);
    checks++; if (cnt_a !== 32'd1) begin errors++; $display("FAIL mid_pre_cnt: got %0d want 1", cnt_a); end
    send_a(16'h5A5A, 8);
    @(negedge clk); mclk_a = 1'b0; rst_n = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if ({act_a, tst_a, beg_a, end_a, enc_a, err_a} !== 6'b0) begin errors++; $display("FAIL mid_reset_flags: got %b want 000000", {act_a, tst_a, beg_a, end_a, enc_a, err_a}); end
    checks++; if (cnt_a !== 32'd0) begin errors++; $display("FAIL mid_reset_cnt: got %0d want 0", cnt_a); end
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    d0 = n_end_a; e0 = n_err_a;
    send_a(16'h5A50, 16);
    repeat (20) @(negedge clk);
    checks++; if (n_end_a - d0 !== 0) begin errors++; $display("FAIL mid_end_idle_pulse: got %0d want 0", n_end_a - d0); end
    checks++; if (n_err_a - e0 !== 0) begin errors++; $display("FAIL mid_end_idle_err: got %0d want 0", n_err_a - e0); end
    checks++; if (act_a !== 1'b0) begin errors++; $display("FAIL mid_end_idle_state: got %b want 0", act_a); end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n  = 1'b0;
    mclk_a = 1'b0;
    mclk_b = 1'b0;
    mosi_a = 1'b0;
    mosi_b = 4'h0;
    repeat (4) @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    test_reset();
    test_begin();
    test_scan_test();
    test_errors();
    test_timeout();
    test_wrap();
    test_reset_mid_word();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
